// File: rtl/print_sequencer.sv
// Frame print sequencer: kicks board_to_string, waits out its warm-up, then
// pulls characters one at a time and forwards them to a byte-wide UART.
module print_sequencer #(
   parameter int WARMUP    = 128,
   parameter int MAX_CHARS = 1024,
   parameter int CNT_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refresh_req,
   output logic             prn_start,
   output logic             prn_nxt,
   input  logic [7:0]       prn_char,
   input  logic             prn_done,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun,
   output logic [CNT_W-1:0] char_cnt
);

   localparam int WCNT_W = $clog2(WARMUP + 1);

   typedef enum logic [2:0] {IDLE, START, WARM, REQ, LATCH, SEND, FINISH} state_t;

   state_t            state, next_state;
   logic [WCNT_W-1:0] wcnt;
   logic              pending;
   logic              handshake;
   logic              last_char;

   assign handshake = tx_valid & tx_ready;
   assign last_char = (char_cnt == CNT_W'(MAX_CHARS - 1));
   assign busy      = (state != IDLE);

   always_comb begin
      next_state = state;
      prn_start  = 1'b0;
      prn_nxt    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:   if (refresh_req || pending) next_state = START;
         START: begin
            prn_start  = 1'b1;
            next_state = WARM;
         end
         WARM:   if (wcnt == WCNT_W'(WARMUP - 1)) next_state = REQ;
         REQ: begin
            prn_nxt    = 1'b1;
            next_state = LATCH;
         end
         // done is only trusted here; anything seen during warm-up is stale
         LATCH:  next_state = prn_done ? FINISH : SEND;
         SEND:   if (handshake) next_state = last_char ? FINISH : REQ;
         FINISH: begin
            frame_done = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= 1'b0;
         wcnt     <= '0;
         char_cnt <= '0;
         overrun  <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
      end else begin
         state <= next_state;
         // single-deep request queue; extra requests while busy merge
         if (state == IDLE)   pending <= 1'b0;
         else if (refresh_req) pending <= 1'b1;
         case (state)
            START: begin
               char_cnt <= '0;
               overrun  <= 1'b0;
               wcnt     <= '0;
            end
            WARM:  wcnt <= wcnt + 1'b1;
            LATCH: if (!prn_done) begin
               tx_data  <= prn_char;
               tx_valid <= 1'b1;
            end
            SEND:  if (handshake) begin
               tx_valid <= 1'b0;
               if (char_cnt != CNT_W'(MAX_CHARS)) char_cnt <= char_cnt + 1'b1;
               if (last_char) overrun <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_print_sequencer.sv
// Directed bench for print_sequencer with a behavioural board_to_string model;
// a second instance with MAX_CHARS=16 and a never-done printer covers overrun.
module tb_print_sequencer;

   localparam int WARMUP    = 128;
   localparam int FRAME_LEN = 22 + 17 * 31;   // 549
   localparam int OVR_MAX   = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        refresh_req = 1'b0;
   logic        prn_start, prn_nxt, prn_done;
   logic [7:0]  prn_char;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy, frame_done, overrun;
   logic [10:0] char_cnt;

   logic        o_refresh = 1'b0;
   logic        o_prn_start, o_prn_nxt;
   logic        o_prn_done = 1'b0;
   logic [7:0]  o_prn_char;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        o_tx_ready = 1'b1;
   logic        o_busy, o_frame_done, o_overrun;
   logic [4:0]  o_char_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_mode = 0;   // 0 always ready, 1 ten-cycle stall per byte, 2 never ready

   print_sequencer #(.WARMUP(WARMUP), .MAX_CHARS(1024), .CNT_W(11)) dut (
      .clk(clk), .rst(rst), .refresh_req(refresh_req),
      .prn_start(prn_start), .prn_nxt(prn_nxt), .prn_char(prn_char), .prn_done(prn_done),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .char_cnt(char_cnt)
   );

   print_sequencer #(.WARMUP(WARMUP), .MAX_CHARS(OVR_MAX), .CNT_W(5)) dut_ovr (
      .clk(clk), .rst(rst), .refresh_req(o_refresh),
      .prn_start(o_prn_start), .prn_nxt(o_prn_nxt), .prn_char(o_prn_char), .prn_done(o_prn_done),
      .tx_data(o_tx_data), .tx_valid(o_tx_valid), .tx_ready(o_tx_ready),
      .busy(o_busy), .frame_done(o_frame_done), .overrun(o_overrun), .char_cnt(o_char_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pchar(input int i);
      return 8'((i * 13 + 5) % 256);
   endfunction

   // printer model: done stays stale from the previous frame until the next pull
   int         p_idx = 0;
   logic [7:0] p_char = 8'h00;
   logic       p_done = 1'b0;
   assign prn_char = p_char;
   assign prn_done = p_done;
   always @(posedge clk) begin
      if (prn_start) p_idx <= 0;
      else if (prn_nxt) begin
         if (p_idx == FRAME_LEN) p_done <= 1'b1;
         else begin
            p_done <= 1'b0;
            p_char <= pchar(p_idx);
            p_idx  <= p_idx + 1;
         end
      end
   end

   int         o_idx = 0;
   logic [7:0] o_char = 8'h00;
   assign o_prn_char = o_char;
   always @(posedge clk) begin
      if (o_prn_start) o_idx <= 0;
      else if (o_prn_nxt) begin
         o_char <= pchar(o_idx);
         o_idx  <= o_idx + 1;
      end
   end

   int stall = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: tx_ready = 1'b1;
         2: tx_ready = 1'b0;
         default: begin
            if (!tx_valid) begin
               stall = 0;
               tx_ready = 1'b0;
            end else begin
               stall++;
               tx_ready = (stall > 10);
            end
         end
      endcase
   end

   logic [7:0] byte_q[$];
   logic [7:0] o_byte_q[$];
   int start_q[$];
   int first_nxt_q[$];
   int done_q[$];
   int n_start = 0, n_done = 0, o_n_done = 0;
   int nxt_viol = 0, stable_viol = 0, n_stall = 0;
   bit got_first = 1'b0;
   logic pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         if (prn_start) begin
            n_start++;
            start_q.push_back(cyc);
            got_first = 1'b0;
         end
         if (prn_nxt) begin
            if (!got_first) begin
               first_nxt_q.push_back(cyc);
               got_first = 1'b1;
            end
            if (tx_valid) nxt_viol++;
         end
         if (frame_done) begin
            n_done++;
            done_q.push_back(cyc);
         end
         if (tx_valid && tx_ready) byte_q.push_back(tx_data);
         if (tx_valid && !tx_ready) n_stall++;
         if (pv && !pr && tx_valid && tx_data != pd) stable_viol++;
         if (o_tx_valid && o_tx_ready) o_byte_q.push_back(o_tx_data);
         if (o_frame_done) o_n_done++;
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
   end

   task automatic clear_logs();
      byte_q.delete();
      start_q.delete();
      first_nxt_q.delete();
      done_q.delete();
      nxt_viol = 0;
      stable_viol = 0;
      n_stall = 0;
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      @(posedge clk); #1;
      refresh_req = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk); #1;
         if (n_done >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({prn_start, prn_nxt, tx_valid, busy, frame_done, overrun} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000", {prn_start, prn_nxt, tx_valid, busy, frame_done, overrun});
      end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      checks++;
      if (char_cnt !== 11'd0) begin errors++; $display("FAIL reset_char_cnt got %0d want 0", char_cnt); end
      checks++;
      if ({o_tx_valid, o_busy, o_overrun, o_char_cnt} !== 8'b0) begin
         errors++;
         $display("FAIL reset_ovr_inst got %b want 0", {o_tx_valid, o_busy, o_overrun, o_char_cnt});
      end
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (n_start !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start got starts=%0d busy=%b want 0/0", n_start, busy);
      end
   endtask

   task automatic test_single_frame();
      int s0, d0, lat, bad;
      bit ok;
      clear_logs();
      s0 = n_start;
      d0 = n_done;
      pulse_refresh();
      wait_frames(d0 + 1, 5000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout got no frame_done want 1"); end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (n_start - s0 !== 1 || n_done - d0 !== 1) begin
         errors++;
         $display("FAIL single_pulses got start=%0d done=%0d want 1/1", n_start - s0, n_done - d0);
      end
      // START, WARMUP cycles of WARM, then REQ
      lat = (start_q.size() >= 1 && first_nxt_q.size() >= 1) ? first_nxt_q[0] - start_q[0] : -1;
      checks++;
      if (lat !== WARMUP + 1) begin errors++; $display("FAIL first_nxt_latency got %0d want %0d", lat, WARMUP + 1); end
      checks++;
      if (byte_q.size() !== FRAME_LEN) begin
         errors++;
         $display("FAIL single_bytes got %0d want %0d", byte_q.size(), FRAME_LEN);
      end
      bad = 0;
      foreach (byte_q[i]) if (byte_q[i] !== pchar(i % FRAME_LEN)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL single_content got %0d bad bytes want 0", bad); end
      checks++;
      if (char_cnt !== 11'd549 || overrun !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_status got cnt=%0d ovr=%b busy=%b want 549/0/0", char_cnt, overrun, busy);
      end
      checks++;
      if (nxt_viol !== 0 || n_stall !== 0) begin
         errors++;
         $display("FAIL single_flow got nxt_viol=%0d stalls=%0d want 0/0", nxt_viol, n_stall);
      end
   endtask

   task automatic test_backpressure();
      int d0, bad;
      bit ok;
      rdy_mode = 1;
      clear_logs();
      d0 = n_done;
      pulse_refresh();
      wait_frames(d0 + 1, 20000, ok);
      repeat (3) @(posedge clk);
      #1;
      rdy_mode = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_timeout got no frame_done want 1"); end
      checks++;
      if (byte_q.size() !== FRAME_LEN) begin errors++; $display("FAIL bp_bytes got %0d want %0d", byte_q.size(), FRAME_LEN); end
      bad = 0;
      foreach (byte_q[i]) if (byte_q[i] !== pchar(i % FRAME_LEN)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bp_content got %0d bad bytes want 0", bad); end
      checks++;
      if (n_stall !== FRAME_LEN * 10) begin errors++; $display("FAIL bp_stalls got %0d want %0d", n_stall, FRAME_LEN * 10); end
      checks++;
      if (stable_viol !== 0 || nxt_viol !== 0) begin
         errors++;
         $display("FAIL bp_stability got data_changes=%0d nxt_in_stall=%0d want 0/0", stable_viol, nxt_viol);
      end
      checks++;
      if (char_cnt !== 11'd549) begin errors++; $display("FAIL bp_char_cnt got %0d want 549", char_cnt); end
   endtask

   task automatic test_refresh_queue();
      int s0, d0, gap, bad;
      bit ok;
      clear_logs();
      s0 = n_start;
      d0 = n_done;
      pulse_refresh();
      repeat (50) @(posedge clk);
      #1;
      pulse_refresh();
      repeat (400) @(posedge clk);
      #1;
      pulse_refresh();
      repeat (300) @(posedge clk);
      #1;
      pulse_refresh();
      wait_frames(d0 + 2, 6000, ok);
      repeat (2000) @(posedge clk);
      #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL queue_timeout got %0d frames want 2", n_done - d0); end
      checks++;
      if (n_start - s0 !== 2 || n_done - d0 !== 2) begin
         errors++;
         $display("FAIL queue_frames got start=%0d done=%0d want 2/2", n_start - s0, n_done - d0);
      end
      // FINISH -> IDLE -> START: second start lands two cycles after frame_done
      gap = (start_q.size() >= 2 && done_q.size() >= 1) ? start_q[1] - done_q[0] : -1;
      checks++;
      if (gap !== 2) begin errors++; $display("FAIL queue_restart_gap got %0d want 2", gap); end
      bad = 0;
      foreach (byte_q[i]) if (byte_q[i] !== pchar(i % FRAME_LEN)) bad++;
      checks++;
      if (byte_q.size() !== 2 * FRAME_LEN || bad !== 0) begin
         errors++;
         $display("FAIL queue_bytes got n=%0d bad=%0d want %0d/0", byte_q.size(), bad, 2 * FRAME_LEN);
      end
   endtask

   task automatic test_overrun();
      int bad;
      bit ok;
      o_byte_q.delete();
      o_refresh = 1'b1;
      @(posedge clk); #1;
      o_refresh = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (o_n_done >= 1) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL ovr_timeout got no frame_done want 1"); end
      bad = 0;
      foreach (o_byte_q[i]) if (o_byte_q[i] !== pchar(i)) bad++;
      checks++;
      if (o_byte_q.size() !== OVR_MAX || bad !== 0) begin
         errors++;
         $display("FAIL ovr_bytes got n=%0d bad=%0d want %0d/0", o_byte_q.size(), bad, OVR_MAX);
      end
      checks++;
      if (o_overrun !== 1'b1 || o_busy !== 1'b0 || o_char_cnt !== 5'd16 || o_n_done !== 1) begin
         errors++;
         $display("FAIL ovr_status got ovr=%b busy=%b cnt=%0d done=%0d want 1/0/16/1", o_overrun, o_busy, o_char_cnt, o_n_done);
      end
      o_refresh = 1'b1;
      @(posedge clk); #1;
      o_refresh = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_overrun !== 1'b0 || o_char_cnt !== 5'd0) begin
         errors++;
         $display("FAIL ovr_clear got ovr=%b cnt=%0d want 0/0", o_overrun, o_char_cnt);
      end
   endtask

   task automatic test_reset_mid_send();
      int d0, bad;
      bit ok, seen;
      rdy_mode = 2;
      pulse_refresh();
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (tx_valid) begin seen = 1'b1; break; end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (!seen || tx_valid !== 1'b1) begin errors++; $display("FAIL midsend_stall got valid=%b want 1", tx_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || char_cnt !== 11'd0 || tx_data !== 8'h00) begin
         errors++;
         $display("FAIL midsend_reset got valid=%b busy=%b cnt=%0d data=%h want 0/0/0/00", tx_valid, busy, char_cnt, tx_data);
      end
      rst = 1'b0;
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      clear_logs();
      d0 = n_done;
      pulse_refresh();
      wait_frames(d0 + 1, 5000, ok);
      repeat (3) @(posedge clk);
      #1;
      bad = 0;
      foreach (byte_q[i]) if (byte_q[i] !== pchar(i % FRAME_LEN)) bad++;
      checks++;
      if (!ok || byte_q.size() !== FRAME_LEN || bad !== 0) begin
         errors++;
         $display("FAIL midsend_refresh got ok=%b n=%0d bad=%0d want 1/%0d/0", ok, byte_q.size(), bad, FRAME_LEN);
      end
      checks++;
      if (char_cnt !== 11'd549 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL midsend_status got cnt=%0d ovr=%b want 549/0", char_cnt, overrun);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_refresh_queue();
      test_overrun();
      test_reset_mid_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
